fifo_drain_stage: RTL and testbench
===================================

# fifo_drain_stage

Registered output stage that sits directly downstream of a `fifo` instance. It pops entries from the FIFO's combinational read port and presents them on a valid/ready interface, holding each entry in an output register so that consumers see no FIFO read path. It sustains one transfer per cycle, stalls cleanly on back-pressure, supports a synchronous flush, and keeps a running count of completed transfers.

## Interface
Parameters:
- `W`, default 32: data width; must equal the upstream FIFO's `W`.

Ports:
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `fifo_out`, input, W: FIFO head entry; valid whenever `fifo_empty`=0.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_pop`, output, 1: pop request to the FIFO; combinational.
- `flush`, input, 1: synchronous discard of the output register.
- `out_valid`, output, 1: the output register holds an entry.
- `out_data`, output, W: the output register contents.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `xfer_count`, output, 32: number of completed output handshakes, modulo 2^32.

## Operation
- State `r_state` ∈ {`DS_EMPTY`, `DS_FULL`}. `out_valid` = (`r_state` == `DS_FULL`).
- `xfer` = `out_valid & out_ready`.
- `fifo_pop` = `!fifo_empty & !flush & (!out_valid | out_ready)`. It is never asserted while the FIFO is empty.
- When `fifo_pop`=1, `fifo_out` is captured into `out_data` at the same edge, and the next state is `DS_FULL`.
- Otherwise, if `xfer`=1 or `flush`=1, the next state is `DS_EMPTY`. In all other cases the state holds.
- `out_data` is only written on a pop. Its value while `out_valid`=0 is don't-care, but it must not change while `out_valid`=1 and `out_ready`=0.
- Transitions:
  - `DS_EMPTY` → `DS_FULL` on pop.
  - `DS_FULL` → `DS_FULL` on `xfer` with pop (back-to-back), or on stall.
  - `DS_FULL` → `DS_EMPTY` on `xfer` without pop, or on `flush`.
- Flush:
  - `flush` suppresses the pop that cycle and empties the output register.
  - It does not modify the FIFO. Flushing FIFO contents is the FIFO owner's responsibility, via its own reset.
  - If `xfer` and `flush` occur in the same cycle, the handshake still completes and is counted.
- Counter: `xfer_count` increments by 1 on every `xfer` edge and wraps from 0xFFFF_FFFF to 0. It is not affected by `flush`.
- Reset values:
  - `r_state` = `DS_EMPTY`, so `out_valid`=0.
  - `xfer_count`=0.
  - `out_data`=0.
  - `fifo_pop`=0 while `reset` is asserted.
- Reset mid-operation: any held entry is dropped. The FIFO has a synchronous reset, so integrators must assert both resets together.

## Timing
- Latency: an entry popped at edge N is visible on `out_data` with `out_valid`=1 after edge N, and can complete its handshake in cycle N+1 at the earliest.
- Throughput: 1 entry per cycle when the FIFO is non-empty and `out_ready`=1 continuously.
- The only combinational input-to-output paths are `fifo_empty`/`out_ready`/`flush` → `fifo_pop`. There is no path from `out_ready` to `out_valid` or `out_data`.
- The FIFO push that fills an empty FIFO at edge N can be popped in cycle N+1 and is output-valid after edge N+1.

## Structure
- Package `fifo_drain_pkg` contains:
  - `typedef enum logic [0:0] {DS_EMPTY, DS_FULL} drain_state_t;`
  - `localparam int XFER_CNT_W = 32`.
- Single module with no sub-modules. The counter is a plain register with increment logic.
- Registers `r_state`, `r_data` and `r_xfer_count` are updated in one `always_ff` block with asynchronous reset (`posedge clk or posedge reset`). All next-state logic lives in one `always_comb` block.

## Test plan
1. Reset, then release with `fifo_empty`=1 → `out_valid`=0, `fifo_pop`=0, `xfer_count`=0 for 10 cycles.
2. Stream: FIFO preloaded with 0x11, 0x22, 0x33, `out_ready`=1 → `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles, `fifo_pop` is high for exactly 3 cycles, and `xfer_count`=3.
3. Back-pressure: entry 0xAA held with `out_ready`=0 for 5 cycles while the FIFO holds 0xBB → `fifo_pop`=0 and `out_data`=0xAA stable. Raise `out_ready` → 0xBB follows the next cycle.
4. Flush: `out_valid`=1 with 0xCC, pulse `flush` with `out_ready`=0 → `out_valid`=0 the next cycle, no pop in the flush cycle, `xfer_count` unchanged. Repeat with `out_ready`=1 → count increments by 1.
5. Counter wrap: force `xfer_count` to 0xFFFF_FFFF, perform one transfer → `xfer_count`=0.
6. Asynchronous reset asserted mid-stream, between clock edges → `out_valid` drops immediately, without waiting for an edge, and `xfer_count`=0.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO drain output stage.
// Holds the two-state occupancy encoding and the transfer counter width.
// No logic lives here; imported by fifo_drain_stage.
package fifo_drain_pkg;

    typedef enum logic [0:0] {DS_EMPTY, DS_FULL} drain_state_t;

    localparam int XFER_CNT_W = 32;

endpackage

// File: rtl/fifo_drain_stage.sv
// Purpose: registered output slot that pops a FIFO head and presents it on valid/ready.
// Latency: entry popped at edge N is valid after edge N; one transfer per cycle sustained.
// Backpressure: out_ready low with a full slot blocks the pop; flush empties the slot.
module fifo_drain_stage
    import fifo_drain_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          fifo_out,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    input  logic                  out_ready,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    drain_state_t            r_state;
    drain_state_t            w_state_nxt;
    logic [W-1:0]            r_data;
    logic [W-1:0]            w_data_nxt;
    logic [XFER_CNT_W-1:0]   r_xfer_count;
    logic [XFER_CNT_W-1:0]   w_xfer_count_nxt;
    logic                    w_full;
    logic                    w_xfer;
    logic                    w_pop;

    // Next-state logic: pop refills the slot (even when it drains the same cycle),
    // otherwise a completed handshake or a flush empties it.
    always_comb begin
        w_full           = (r_state == DS_FULL);
        w_xfer           = w_full & out_ready;
        // Reset gating keeps the FIFO from being popped while both sides are held in reset.
        w_pop            = !reset & !fifo_empty & !flush & (!w_full | out_ready);
        w_state_nxt      = r_state;
        w_data_nxt       = r_data;
        w_xfer_count_nxt = r_xfer_count;

        if (w_pop) begin
            w_state_nxt = DS_FULL;
            w_data_nxt  = fifo_out;
        end else if (w_xfer || flush) begin
            w_state_nxt = DS_EMPTY;
        end

        // Flush never cancels a handshake that completes in the same cycle.
        if (w_xfer) begin
            w_xfer_count_nxt = r_xfer_count + 1'b1;
        end
    end

    // State, output register and transfer counter; async reset drops any held entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= DS_EMPTY;
            r_data       <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_data       <= w_data_nxt;
            r_xfer_count <= w_xfer_count_nxt;
        end
    end

    assign fifo_pop   = w_pop;
    assign out_valid  = w_full;
    assign out_data   = r_data;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Bench for fifo_drain_stage: a queue stands in for the upstream FIFO and a
// slot/counter model tracks what the consumer should see each cycle.
module tb_fifo_drain_stage;

    logic        clk;
    logic        reset;
    logic [31:0] fifo_out;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [31:0] xfer_count;

    fifo_drain_stage #(.W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_out   (fifo_out),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: upstream FIFO contents, held slot, transfer count.
    logic [31:0] q[$];
    bit          m_held;
    logic [31:0] m_val;
    logic [31:0] m_cnt;
    int          n_checks;
    int          n_passed;
    int          n_pops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0);
        fifo_out   = (q.size() != 0) ? q[0] : 32'h0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, m_held});
        chk({tag, "_count"}, xfer_count, m_cnt);
        if (m_held) chk({tag, "_data"}, out_data, m_val);
    endtask

    // One clock cycle: inputs are set just after a falling edge, the pop is checked
    // before the rising edge, outputs are checked at the next falling edge.
    task automatic cycle(input string tag);
        bit exp_pop;
        bit xfer;
        drive_fifo();
        #1;
        exp_pop = (q.size() != 0) && !flush && (!m_held || out_ready);
        chk({tag, "_pop"}, {31'b0, fifo_pop}, {31'b0, exp_pop});
        if (fifo_pop) n_pops++;
        @(posedge clk);
        xfer = m_held && out_ready;
        if (xfer) m_cnt = m_cnt + 32'd1;
        if (exp_pop) begin
            m_held = 1'b1;
            m_val  = q.pop_front();
        end else if (xfer || flush) begin
            m_held = 1'b0;
        end
        @(negedge clk);
        drive_fifo();
        check_outputs(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_held = 1'b0;
        m_val  = 32'h0;
        m_cnt  = 32'h0;
    endtask

    initial begin
        n_checks  = 0;
        n_passed  = 0;
        n_pops    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        drive_fifo();

        // Reset state, then idle with an empty FIFO.
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pop",   {31'b0, fifo_pop},  32'd0);
        chk("rst_count", xfer_count,         32'd0);
        chk("rst_data",  out_data,           32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle("idle");

        // Streaming: three preloaded entries drain back to back.
        q.push_back(32'h11); q.push_back(32'h22); q.push_back(32'h33);
        out_ready = 1'b1;
        n_pops = 0;
        cycle("s0"); chk("s0_d", out_data, 32'h11);
        cycle("s1"); chk("s1_d", out_data, 32'h22);
        cycle("s2"); chk("s2_d", out_data, 32'h33);
        cycle("s3");
        cycle("s4");
        chk("stream_pops",  n_pops,     32'd3);
        chk("stream_count", xfer_count, 32'd3);

        // Back-pressure: 0xAA held while 0xBB waits in the FIFO.
        out_ready = 1'b0;
        q.push_back(32'hAA); q.push_back(32'hBB);
        cycle("bp_load");
        for (int i = 0; i < 5; i++) begin
            cycle("bp_hold");
            chk("bp_hold_d", out_data, 32'hAA);
        end
        out_ready = 1'b1;
        cycle("bp_rel");
        chk("bp_rel_d", out_data, 32'hBB);
        cycle("bp_drain");

        // Flush with the consumer stalled: entry discarded, not counted, no pop.
        out_ready = 1'b0;
        q.push_back(32'hCC);
        cycle("fl_load");
        q.push_back(32'hDD);
        flush = 1'b1;
        cycle("fl_stall");
        chk("fl_stall_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;
        cycle("fl_refill");
        // Flush coinciding with a handshake: still counted once.
        out_ready = 1'b1;
        flush = 1'b1;
        cycle("fl_xfer");
        flush = 1'b0;

        // Counter wrap: preset the count to all ones, then complete one transfer.
        out_ready = 1'b0;
        q.push_back(32'hEE);
        cycle("wr_load");
        force dut.r_xfer_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_xfer_count;
        m_cnt = 32'hFFFF_FFFF;
        chk("wr_preset", xfer_count, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        cycle("wr_xfer");
        chk("wr_zero", xfer_count, 32'h0);

        // Randomized traffic with random stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && q.size() < 8) q.push_back($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycle("rnd");
        end
        flush = 1'b0;

        // Asynchronous reset between edges while streaming.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) q.push_back(32'h100 + i);
        cycle("ar_s0");
        cycle("ar_s1");
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_count", xfer_count,         32'd0);
        chk("ar_pop",   {31'b0, fifo_pop},  32'd0);
        model_reset();
        drive_fifo();
        @(negedge clk);
        check_outputs("ar_hold");
        reset = 1'b0;
        q.push_back(32'h5A);
        cycle("ar_after");
        cycle("ar_after2");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
